// File: rtl/ks_pkg.sv
// Shared constants and helpers for the Kogge-Stone adder datapath.
// The prefix span doubles at every level of the carry tree.
package ks_pkg;

  localparam int KS_WIDTH  = 32;
  localparam int KS_LEVELS = $clog2(KS_WIDTH);

  typedef logic [KS_WIDTH-1:0] ks_vec_t;

  function automatic int ks_span(input int k);
    return 1 << (k - 1);
  endfunction

endpackage

// File: rtl/ks_black_cell.sv
// Kogge-Stone black cell: merges a high group (gh/ph) with the adjacent
// low group (gl/pl) into one wider generate/propagate pair.
module ks_black_cell (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);

  assign g = gh | (ph & gl);
  assign p = ph & pl;

endmodule

// File: rtl/ks_sum_pipe.sv
// Consumer end of the Kogge-Stone adder: registered prefix levels, then sum
// and carry-out, behind a valid/ready pipeline that collapses bubbles.
module ks_sum_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_pk,
  input  logic [WIDTH-1:0] i_gk,
  input  logic             i_c0,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int LEVELS = $clog2(WIDTH);

  if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $fatal(1, "ks_sum_pipe: WIDTH must be a power of two and at least 2");
  end

  // g_nx[k]/p_nx[k] are the combinational results of prefix level k; stage
  // s (S(s+1)) registers level s, the output stage consumes level LEVELS.
  logic [LEVELS:0][WIDTH-1:0]   g_nx;
  logic [LEVELS-1:0][WIDTH-1:0] p_nx;

  logic [WIDTH-1:0] g_p  [LEVELS];
  logic [WIDTH-1:0] p_p  [LEVELS];
  logic [WIDTH-1:0] pk_p [LEVELS];
  logic [LEVELS-1:0] c0_p;
  logic [LEVELS:0]   vld_p;
  logic [LEVELS:0]   en;
  logic [WIDTH-1:0]  sum_p;
  logic              cout_p;

  // Level 0: fold the carry-in into bit 0 so every G[i] becomes a true carry.
  assign g_nx[0] = i_gk | {{(WIDTH-1){1'b0}}, i_pk[0] & i_c0};
  assign p_nx[0] = i_pk;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int D = ks_span(k);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_merge
        if (k < LEVELS) begin : g_black
          ks_black_cell u_cell (
            .gh (g_p[k-1][i]),
            .ph (p_p[k-1][i]),
            .gl (g_p[k-1][i-D]),
            .pl (p_p[k-1][i-D]),
            .g  (g_nx[k][i]),
            .p  (p_nx[k][i])
          );
        end else begin : g_gray
          // The last level feeds only the sum, so its group propagate is dead.
          assign g_nx[k][i] = g_p[k-1][i] | (p_p[k-1][i] & g_p[k-1][i-D]);
        end
      end else begin : g_pass
        assign g_nx[k][i] = g_p[k-1][i];
        if (k < LEVELS) begin : g_pass_p
          assign p_nx[k][i] = p_p[k-1][i];
        end
      end
    end
  end

  // A stage may load whenever it or any stage below it is empty, or the
  // consumer is draining; this is the unrolled form of en_k = ~v_k | en_(k+1).
  for (genvar s = 0; s <= LEVELS; s++) begin : g_en
    assign en[s] = i_ready | ~(&vld_p[LEVELS:s]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p  <= '0;
      c0_p   <= '0;
      sum_p  <= '0;
      cout_p <= 1'b0;
      for (int s = 0; s < LEVELS; s++) begin
        g_p[s]  <= '0;
        p_p[s]  <= '0;
        pk_p[s] <= '0;
      end
    end else begin
      // S1: capture the folded level-0 vectors and the raw operands
      if (en[0]) begin
        vld_p[0] <= i_valid;
        g_p[0]   <= g_nx[0];
        p_p[0]   <= p_nx[0];
        pk_p[0]  <= i_pk;
        c0_p[0]  <= i_c0;
      end
      // S2..S(LEVELS): one prefix level per stage
      for (int s = 1; s < LEVELS; s++) begin
        if (en[s]) begin
          vld_p[s] <= vld_p[s-1];
          g_p[s]   <= g_nx[s];
          p_p[s]   <= p_nx[s];
          pk_p[s]  <= pk_p[s-1];
          c0_p[s]  <= c0_p[s-1];
        end
      end
      // S(LEVELS+1): last prefix level, sum and carry-out
      if (en[LEVELS]) begin
        vld_p[LEVELS] <= vld_p[LEVELS-1];
        sum_p         <= pk_p[LEVELS-1] ^ {g_nx[LEVELS][WIDTH-2:0], c0_p[LEVELS-1]};
        cout_p        <= g_nx[LEVELS][WIDTH-1];
      end
    end
  end

  assign o_ready = en[0];
  assign o_valid = vld_p[LEVELS];
  assign o_sum   = sum_p;
  assign o_cout  = cout_p;

endmodule

// File: tb/tb_ks_sum_pipe.sv
// Randomized bench for ks_sum_pipe: a queue of a+b+c0 results is compared
// against every result the pipe hands over.
module tb_ks_sum_pipe;

  localparam int W   = 32;
  localparam int STG = 6;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [W-1:0] i_pk = '0;
  logic [W-1:0] i_gk = '0;
  logic         i_c0 = 1'b0;
  logic         o_valid;
  logic         i_ready = 1'b0;
  logic [W-1:0] o_sum;
  logic         o_cout;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;

  logic [W:0] exp_q [$];
  logic [W:0] cur_exp = '0;
  logic [W:0] held    = '0;
  logic       hold_prev = 1'b0;

  ks_sum_pipe #(.WIDTH(W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_pk    (i_pk),
    .i_gk    (i_gk),
    .i_c0    (i_c0),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_cout  (o_cout)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present operands a,b,c0 in the KS pre-processed form; the model keeps
  // the plain arithmetic sum.
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    i_valid = v;
    i_pk    = a ^ b;
    i_gk    = a & b;
    i_c0    = c;
    cur_exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endtask

  function automatic logic [W-1:0] rand_word();
    case ($urandom % 6)
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called at a falling edge: sample just before the next rising edge,
  // account both handshakes, then return at the following falling edge.
  task automatic step();
    #4;
    if (hold_prev) begin
      chk("hold_vld", {63'd0, o_valid}, 64'd1);
      chk("hold_data", {31'd0, o_cout, o_sum}, {31'd0, held});
    end
    chk("o_ready", {63'd0, o_ready}, {63'd0, (exp_q.size() < STG) || i_ready});
    if (o_valid && i_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", {63'd0, o_valid}, 64'd0);
      else begin
        chk("result", {31'd0, o_cout, o_sum}, {31'd0, exp_q.pop_front()});
        n_out++;
      end
    end
    hold_prev = o_valid && !i_ready;
    held      = {o_cout, o_sum};
    if (i_valid && o_ready) exp_q.push_back(cur_exp);
    @(negedge i_clk);
  endtask

  initial begin
    int lat;
    int base;
    int guard;
    int bub;

    // Reset
    i_rst_n = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_sum", {31'd0, o_cout, o_sum}, 64'd0);
    i_rst_n = 1'b1;
    chk("rst_ready", {63'd0, o_ready}, 64'd1);

    // All-ones plus one wraps to zero with carry out; latency counted in edges
    i_ready = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    lat = 1;
    while (!o_valid && lat < 20) begin step(); lat++; end
    chk("latency1", lat, STG);
    chk("wrap_sum", {31'd0, o_cout, o_sum}, 64'h1_0000_0000);
    step();

    // Carry-in ripples across the whole word, then a back-to-back overflow
    drive(1'b1, 32'h7FFF_FFFF, 32'h0, 1'b1);
    step();
    drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    lat = 2;
    while (!o_valid && lat < 20) begin step(); lat++; end
    chk("latency2", lat, STG);
    chk("cin_sum", {31'd0, o_cout, o_sum}, 64'h0_8000_0000);
    step();
    chk("b2b_valid", {63'd0, o_valid}, 64'd1);
    chk("b2b_sum", {31'd0, o_cout, o_sum}, 64'h1_0000_0000);
    step();

    // Ten back-to-back random adds drain at one per cycle
    base = n_out;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, $urandom, $urandom, 1'($urandom));
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    repeat (6) step();
    chk("stream_cnt", n_out - base, 10);

    // Fill under backpressure with a two-cycle bubble after three accepts
    i_ready = 1'b0;
    guard = 0;
    bub = 0;
    while (exp_q.size() < STG && guard < 30) begin
      if (exp_q.size() == 3 && bub < 2) begin
        drive(1'b0, '0, '0, 1'b0);
        bub++;
      end else drive(1'b1, rand_word(), rand_word(), 1'($urandom));
      step();
      guard++;
    end
    chk("fill_cnt", exp_q.size(), STG);
    drive(1'b1, $urandom, $urandom, 1'b1);
    repeat (3) step();
    chk("full_ready", {63'd0, o_ready}, 64'd0);
    // One cycle of drain: one out, one in, in the same edge
    i_ready = 1'b1;
    drive(1'b1, $urandom, $urandom, 1'b0);
    step();
    i_ready = 1'b0;
    drive(1'b1, $urandom, $urandom, 1'b1);
    step();
    chk("swap_cnt", exp_q.size(), STG);
    i_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    repeat (8) step();
    chk("drain_empty", exp_q.size(), 0);

    // Random handshakes on both sides with corner-heavy operands
    for (int k = 0; k < 400; k++) begin
      i_ready = ($urandom % 3) != 0;
      drive(($urandom % 4) != 0, rand_word(), rand_word(), 1'($urandom));
      step();
    end
    i_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    repeat (10) step();
    chk("rand_empty", exp_q.size(), 0);

    // Reset with three results in flight, one of them already at the output
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, $urandom | 32'h1, $urandom, 1'b1);
      step();
    end
    i_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    repeat (5) step();
    chk("pre_rst_valid", {63'd0, o_valid}, 64'd1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, o_valid}, 64'd0);
    chk("mid_rst_data", {31'd0, o_cout, o_sum}, 64'd0);
    exp_q.delete();
    hold_prev = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk("post_rst_ready", {63'd0, o_ready}, 64'd1);
    i_ready = 1'b1;
    repeat (20) step();
    chk("no_stale", {63'd0, o_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
